// File: rtl/muldiv_arbiter.sv
// Purpose: round-robin sequencer sharing one multiplier between two requesters.
// Latency: ack one cycle after the grant edge, done/res MUL_LAT+2 cycles after it.
// Backpressure: requests wait without ack while busy; one operation per MUL_LAT+3 cycles.
module muldiv_arbiter #(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  output logic               ack0,
  output logic               done0,
  output logic [2*WIDTH-1:0] res0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack1,
  output logic               done1,
  output logic [2*WIDTH-1:0] res1,
  output logic               mul_en,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_out,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MUL_LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       owner;
  logic       last;
  logic       grant_port;
  logic       any_req;

  assign any_req = req0 | req1;

  // Round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
  always_comb begin
    grant_port = 1'b0;
    if (req0 && req1) grant_port = ~last;
    else              grant_port = req1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs; ack/done are steered to the recorded owner.
  always_comb begin
    state_nxt = state;
    ack0      = 1'b0;
    ack1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    mul_en    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_nxt = LOAD;
      end
      LOAD: begin
        ack0      = ~owner;
        ack1      = owner;
        state_nxt = RUN;
      end
      RUN: begin
        mul_en = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        done0     = ~owner;
        done1     = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operands latch only on a grant, product captured on the last RUN edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= 8'd0;
      owner <= 1'b0;
      last  <= 1'b1;
      mul_a <= '0;
      mul_b <= '0;
      res0  <= '0;
      res1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= grant_port;
            mul_a <= grant_port ? a1 : a0;
            mul_b <= grant_port ? b1 : b0;
          end
        end
        LOAD: cnt <= 8'd0;
        RUN: begin
          cnt <= cnt + 8'd1;
          if (cnt == CNT_LAST) begin
            last <= owner;
            if (owner) res1 <= mul_out;
            else       res0 <= mul_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Purpose: directed scoreboard bench for muldiv_arbiter with a latency-accurate multiplier model.
// Latency: model presents the product only in the MUL_LAT-th consecutive enabled cycle.
// Backpressure: requesters hold req until ack, as the block expects.
module tb_muldiv_arbiter;

  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        ack0, ack1, done0, done1;
  logic [15:0] res0, res1;
  logic        mul_en;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_out;
  logic        busy;

  typedef struct {
    int          port;
    logic [15:0] res;
  } exp_t;

  exp_t sbq[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_ack_cyc  = 0;
  int   last_done_cyc = 0;
  int   ack_gap       = 0;
  int   ack_from_done = 0;

  muldiv_arbiter #(.WIDTH(8), .MUL_LAT(ML)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .ack0   (ack0),
    .done0  (done0),
    .res0   (res0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .ack1   (ack1),
    .done1  (done1),
    .res1   (res1),
    .mul_en (mul_en),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_out(mul_out),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: signed product valid only after ML consecutive enabled cycles.
  logic [7:0]         en_run = 8'd0;
  logic signed [15:0] sa16, sb16, prod;
  assign sa16    = {{8{mul_a[7]}}, mul_a};
  assign sb16    = {{8{mul_b[7]}}, mul_b};
  assign prod    = sa16 * sb16;
  assign mul_out = (mul_en && en_run == 8'(ML - 1)) ? prod : 16'hBAD0;

  always @(posedge clk) en_run <= mul_en ? en_run + 8'd1 : 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int port, input logic [15:0] res);
    exp_t e;
    e.port = port;
    e.res  = res;
    sbq.push_back(e);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ack0"},  ack0, 0);
    chk({tag, "_ack1"},  ack1, 0);
    chk({tag, "_done0"}, done0, 0);
    chk({tag, "_done1"}, done1, 0);
    chk({tag, "_res0"},  res0, 0);
    chk({tag, "_res1"},  res1, 0);
    chk({tag, "_mul_en"}, mul_en, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
    chk({tag, "_busy"},  busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
  endtask

  // drop: 0 keep requests, 1 drop the owner's req at ack, 2 drop both.
  // tweak: scramble the owner's operands right after ack.
  task automatic serve(input int drop, input bit tweak, output int port);
    int          n;
    int          ack_t;
    int          en_n;
    int          spurious;
    logic [15:0] other_res;
    logic [7:0]  sa, sb;
    exp_t        e;
    port = -1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack0 || ack1) && n < 60);
    if (!(ack0 || ack1)) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    port  = ack1 ? 1 : 0;
    ack_t = cyc;
    ack_gap       = cyc - last_ack_cyc;
    ack_from_done = cyc - last_done_cyc;
    last_ack_cyc  = cyc;
    chk("ack_onehot", {31'd0, ack0 & ack1}, 0);
    chk("load_en", mul_en, 0);
    chk("load_busy", busy, 1);
    sa = (port == 1) ? a1 : a0;
    sb = (port == 1) ? b1 : b0;
    chk("grant_mul_a", mul_a, sa);
    chk("grant_mul_b", mul_b, sb);
    other_res = (port == 1) ? res0 : res1;
    if (drop == 2) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end else if (drop == 1) begin
      if (port == 1) req1 = 1'b0;
      else           req0 = 1'b0;
    end
    if (tweak) begin
      if (port == 1) begin a1 = 8'hFF; b1 = 8'hFF; end
      else           begin a0 = 8'hFF; b0 = 8'hFF; end
    end
    n = 0;
    en_n = 0;
    spurious = 0;
    do begin
      @(negedge clk);
      n++;
      if (mul_en) en_n++;
      if (ack0 || ack1) spurious++;
      if (tweak && n == 1) begin
        chk("hold_mul_a", mul_a, sa);
        chk("hold_mul_b", mul_b, sb);
      end
    end while (!(done0 || done1) && n < 300);
    if (!(done0 || done1)) begin
      chk("done_timeout", 0, 1);
      return;
    end
    last_done_cyc = cyc;
    chk("done_latency", cyc - ack_t, ML + 1);
    chk("en_cycles", en_n, ML);
    chk("done_port", done1 ? 1 : 0, port);
    chk("done_busy", busy, 1);
    chk("done_mul_en", mul_en, 0);
    chk("ack_in_run", spurious, 0);
    chk("other_res", (port == 1) ? res0 : res1, other_res);
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("sb_port", port, e.port);
      chk("sb_res", (port == 1) ? res1 : res0, e.res);
    end
    @(negedge clk);
    chk("done_pulse", {31'd0, done0 | done1}, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int p;
    int n;
    int nd;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Single port 0 operation, signed product.
    @(negedge clk);
    req0 = 1'b1; a0 = 8'h10; b0 = 8'hFE;
    push(0, 16'hFFE0);
    serve(1, 1'b0, p);
    chk("t1_port", p, 0);
    chk("t1_res1", res1, 0);

    // Simultaneous requests after reset: port 0 first, then port 1 on the next IDLE.
    do_reset();
    req0 = 1'b1; a0 = 8'd3; b0 = 8'd5;
    req1 = 1'b1; a1 = 8'd7; b1 = 8'd9;
    push(0, 16'h000F);
    push(1, 16'h003F);
    serve(1, 1'b0, p);
    chk("t2_first", p, 0);
    serve(1, 1'b0, p);
    chk("t2_second", p, 1);
    chk("t2_ack_gap", ack_gap, ML + 3);
    chk("t2_ack_after_done", ack_from_done, 2);

    // Both ports hold req for four operations: strict alternation.
    req0 = 1'b1; a0 = 8'd4;  b0 = 8'hFD;
    req1 = 1'b1; a1 = 8'h80; b1 = 8'h80;
    for (int i = 0; i < 4; i++) push(i % 2, (i % 2 == 1) ? 16'h4000 : 16'hFFF4);
    for (int i = 0; i < 4; i++) begin
      serve((i == 3) ? 2 : 0, 1'b0, p);
      chk("t3_order", p, i % 2);
      if (i > 0) chk("t3_ack_gap", ack_gap, ML + 3);
    end

    // Port 1 requests during port 0's RUN: waits for the next IDLE.
    @(negedge clk);
    req0 = 1'b1; a0 = 8'd2; b0 = 8'd7;
    push(0, 16'h000E);
    push(1, 16'hFF9C);
    fork
      begin
        repeat (5) @(negedge clk);
        req1 = 1'b1; a1 = 8'd10; b1 = 8'hF6;
      end
    join_none
    serve(1, 1'b0, p);
    chk("t4_first", p, 0);
    serve(1, 1'b0, p);
    chk("t4_second", p, 1);
    chk("t4_ack_after_done", ack_from_done, 2);

    // Reset during RUN with cnt=4 discards the operation.
    do_reset();
    @(negedge clk);
    req0 = 1'b1; a0 = 8'd2; b0 = 8'd3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack0 && n < 20);
    chk("t5_ack", ack0, 1);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_run_en", mul_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("t5_abort");
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done0 || done1) nd++;
    end
    chk("t5_no_done", nd, 0);
    chk("t5_res0", res0, 0);
    req0 = 1'b1; a0 = 8'd2; b0 = 8'd3;
    push(0, 16'h0006);
    serve(1, 1'b0, p);
    chk("t5_fresh_port", p, 0);

    // Operands changed right after ack are ignored.
    @(negedge clk);
    req0 = 1'b1; a0 = 8'd5; b0 = 8'd6;
    push(0, 16'h001E);
    serve(1, 1'b1, p);
    chk("t6_port", p, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
